// File: rtl/stage6_seq_ctrl_if.sv
// Request/status bundle between the stage-6 sequencer and its datapath/host.
// The master drives start/abort/stall/boundaries; the slave (sequencer) returns status.
interface stage6_seq_ctrl_if #(
  parameter int PARA    = 16,
  parameter int NUM_BND = 8
);
  logic                            start_i;
  logic                            abort_i;
  logic                            stall_i;
  logic [NUM_BND-1:0][PARA-1:0]    bnd_i;
  logic                            busy_o;
  logic                            done_o;
  logic                            err_o;
  logic [PARA-1:0]                 step_o;
  logic [4:0]                      stage_o;
  logic                            mode_o;
  logic                            red_clr_o;
  logic                            finished_o;

  modport master (
    output start_i, abort_i, stall_i, bnd_i,
    input  busy_o, done_o, err_o, step_o, stage_o, mode_o, red_clr_o, finished_o
  );

  modport slave (
    input  start_i, abort_i, stall_i, bnd_i,
    output busy_o, done_o, err_o, step_o, stage_o, mode_o, red_clr_o, finished_o
  );
endinterface

// File: rtl/stage6_seq_ctrl.sv
// Stage-6 attention pipeline sequencer: start/abort/done step counter with stage decode.
// Optional stall support is enabled by defining STAGE6_SEQ_STALL_EN.
module stage6_seq_ctrl #(
  parameter int PARA    = 16,
  parameter int NUM_BND = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  stage6_seq_ctrl_if.slave   bus
);

  typedef logic [NUM_BND-1:0][PARA-1:0] bnd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_r, state_s;
  logic [PARA-1:0] step_r, step_s;
  bnd_t            bnd_r, bnd_s;
  logic            busy_r, done_r, err_r, err_s;
  logic [4:0]      stage_s;
  logic            finished_s, mode_s, red_clr_s, stall_s, valid_s;

  // Boundaries are usable only if every stage has non-negative length.
  function automatic logic bnd_monotonic(input bnd_t b);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < NUM_BND - 1; k++) begin
      ok = ok & (b[k] <= b[k+1]);
    end
    return ok;
  endfunction

`ifdef STAGE6_SEQ_STALL_EN
  assign stall_s = bus.stall_i;
`else
  logic stall_unused_s;
  assign stall_unused_s = bus.stall_i;
  assign stall_s        = 1'b0;
`endif

  // Stage decode: lowest boundary still ahead of the step; empty stages fall through.
  always_comb begin
    stage_s = 5'(NUM_BND);
    for (int k = NUM_BND - 1; k >= 0; k--) begin
      if (step_r < bnd_r[k]) begin
        stage_s = 5'(k);
      end else begin
        stage_s = stage_s;
      end
    end
  end

  assign finished_s = (stage_s == 5'(NUM_BND));
  assign mode_s     = busy_r && (stage_s <= 5'd1);
  // Coincident boundaries collapse into a single OR term, so only one pulse results.
  assign red_clr_s  = busy_r && ((step_r == bnd_r[1]) || (step_r == bnd_r[4]) ||
                                 (step_r == bnd_r[5]) || (step_r == bnd_r[6]));
  assign valid_s    = bnd_monotonic(bus.bnd_i);

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_s = state_r;
    step_s  = step_r;
    bnd_s   = bnd_r;
    err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (valid_s) begin
            bnd_s   = bus.bnd_i;
            step_s  = {PARA{1'b0}};
            state_s = ST_RUN;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Terminal check beats abort, abort beats stall/increment.
        if (finished_s) begin
          state_s = ST_DONE;
        end else if (bus.abort_i) begin
          state_s = ST_IDLE;
        end else if (stall_s) begin
          step_s = step_r;
        end else begin
          step_s = step_r + {{(PARA-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counter, boundary and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      step_r  <= {PARA{1'b0}};
      bnd_r   <= '{default: {PARA{1'b0}}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      step_r  <= step_s;
      bnd_r   <= bnd_s;
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
      err_r   <= err_s;
    end
  end

  assign bus.busy_o     = busy_r;
  assign bus.done_o     = done_r;
  assign bus.err_o      = err_r;
  assign bus.step_o     = step_r;
  assign bus.stage_o    = stage_s;
  assign bus.mode_o     = mode_s;
  assign bus.red_clr_o  = red_clr_s;
  assign bus.finished_o = finished_s;

endmodule
